// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and fetch FSM state encoding
package cpu_pkg;
    localparam int AW = 10;
    localparam int DW = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: DEPTH x AW return-address LIFO with occupancy count
module ret_stack #(
    parameter int AW = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            din,
    output logic [AW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = PW + 1;
    localparam logic [SW-1:0] FULL_CNT = SW'(DEPTH);
    logic [AW-1:0] mem [DEPTH];
    assign full = count == FULL_CNT;
    assign empty = count == '0;
    // low bits of DEPTH wrap to 0, so index-1 lands on the top entry when full
    assign dout = mem[count[PW-1:0] - 1'b1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= clr ? '0 : push ? count + 1'b1 : pop ? count - 1'b1 : count;
    end
    always_ff @(posedge clk) begin
        if (push)
            mem[count[PW-1:0]] <= din;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter, fetch qualification and call/return sequencing
module fetch_sequencer #(
    parameter int AW = cpu_pkg::AW,
    parameter int DW = cpu_pkg::DW,
    parameter int DEPTH = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     halt_req,
    input  logic                     stall,
    input  logic                     jump_en,
    input  logic                     call_en,
    input  logic                     ret_en,
    input  logic [AW-1:0]            target,
    input  logic [DW-1:0]            rd,
    output logic [AW-1:0]            pc,
    output logic [DW-1:0]            instr,
    output logic                     fetch_valid,
    output logic                     running,
    output logic                     error,
    output logic [$clog2(DEPTH):0]   sp
);
    import cpu_pkg::*;
    state_t state, state_nxt;
    logic [AW-1:0] pc_nxt, pc_inc, top;
    logic go, active, do_ret, do_call, do_jump, push, pop, full, empty;
    ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
        .clk(clk), .reset(reset), .clr(go), .push(push), .pop(pop),
        .din(pc_inc), .dout(top), .full(full), .empty(empty), .count(sp)
    );
    assign running = state == RUN;
    assign error = state == ERR;
    assign fetch_valid = running && !stall;
    assign instr = rd;
    assign pc_inc = pc + 1'b1;
    // halt beats stall and every flow control; stall beats ret/call/jump
    always_comb begin
        go = start && !running;
        active = running && !halt_req && !stall;
        do_ret = active && ret_en;
        do_call = active && !ret_en && call_en;
        do_jump = active && !ret_en && !call_en && jump_en;
        pop = do_ret && !empty;
        push = do_call && !full;
        pc_nxt = go ? RESET_PC : pop ? top : (push || do_jump) ? target
               : (active && !do_ret && !do_call) ? pc_inc : pc;
        state_nxt = go ? RUN : (running && halt_req) ? IDLE
                  : ((do_ret && empty) || (do_call && full)) ? ERR : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenario tests for fetch_sequencer
module tb_fetch_sequencer;
    logic clk = 0, reset = 0, start = 0, halt_req = 0, stall = 0;
    logic jump_en = 0, call_en = 0, ret_en = 0;
    logic [9:0] target = '0;
    logic [15:0] rd;
    logic [9:0] pc;
    logic [15:0] instr;
    logic fetch_valid, running, error;
    logic [3:0] sp;
    int tests = 0, fails = 0;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
        .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en), .target(target), .rd(rd),
        .pc(pc), .instr(instr), .fetch_valid(fetch_valid), .running(running),
        .error(error), .sp(sp)
    );

    always #5 clk = ~clk;
    assign rd = 16'hA000 ^ {6'd0, pc};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        start = 0; halt_req = 0; stall = 0; jump_en = 0; call_en = 0; ret_en = 0; target = '0;
    endtask

    task automatic do_start();
        idle_in();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        #12;
        tests++;
        if (pc !== 10'd0 || running !== 1'b0 || error !== 1'b0 || fetch_valid !== 1'b0 || sp !== 4'd0) begin
            fails++;
            $display("FAIL reset: pc=%0d run=%b err=%b fv=%b sp=%0d, want 0 0 0 0 0", pc, running, error, fetch_valid, sp);
        end
        @(negedge clk);
        reset = 0;
        jump_en = 1; target = 10'd77;
        tick();
        tests++;
        if (pc !== 10'd0 || running !== 1'b0) begin
            fails++;
            $display("FAIL idle_ignore: pc=%0d run=%b, want 0 0", pc, running);
        end
        idle_in();
    endtask

    task automatic test_increment();
        do_start();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (pc !== 10'(i) || fetch_valid !== 1'b1 || instr !== (16'hA000 ^ 16'(i))) begin
                fails++;
                $display("FAIL incr[%0d]: pc=%0d fv=%b instr=%h, want pc=%0d fv=1 instr=%h",
                         i, pc, fetch_valid, instr, i, 16'hA000 ^ 16'(i));
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        jump_en = 1; target = 10'd1023;
        tick();
        idle_in();
        tests++;
        if (pc !== 10'd1023) begin
            fails++;
            $display("FAIL wrap_jump: pc=%0d, want 1023", pc);
        end
        tick();
        tests++;
        if (pc !== 10'd0 || error !== 1'b0 || running !== 1'b1) begin
            fails++;
            $display("FAIL wrap: pc=%0d err=%b run=%b, want 0 0 1", pc, error, running);
        end
    endtask

    task automatic test_call_ret();
        jump_en = 1; target = 10'd5;
        tick();
        idle_in();
        call_en = 1; target = 10'd100;
        tick();
        idle_in();
        tests++;
        if (pc !== 10'd100 || sp !== 4'd1) begin
            fails++;
            $display("FAIL call: pc=%0d sp=%0d, want 100 1", pc, sp);
        end
        ret_en = 1;
        tick();
        idle_in();
        tests++;
        if (pc !== 10'd6 || sp !== 4'd0) begin
            fails++;
            $display("FAIL ret: pc=%0d sp=%0d, want 6 0", pc, sp);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 8; k++) begin
            call_en = 1; target = 10'(200 + k);
            tick();
        end
        tests++;
        if (pc !== 10'd207 || sp !== 4'd8 || error !== 1'b0) begin
            fails++;
            $display("FAIL fill: pc=%0d sp=%0d err=%b, want 207 8 0", pc, sp, error);
        end
        target = 10'd300;
        tick();
        idle_in();
        tests++;
        if (error !== 1'b1 || pc !== 10'd207 || sp !== 4'd8 || running !== 1'b0 || fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL overflow: err=%b pc=%0d sp=%0d run=%b fv=%b, want 1 207 8 0 0",
                     error, pc, sp, running, fetch_valid);
        end
        do_start();
        tests++;
        if (pc !== 10'd0 || sp !== 4'd0 || running !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL restart: pc=%0d sp=%0d run=%b err=%b, want 0 0 1 0", pc, sp, running, error);
        end
    endtask

    task automatic test_underflow();
        ret_en = 1; stall = 1;
        tick();
        tests++;
        if (error !== 1'b0 || pc !== 10'd0 || fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_ret: err=%b pc=%0d fv=%b, want 0 0 0", error, pc, fetch_valid);
        end
        stall = 0;
        tick();
        idle_in();
        tests++;
        if (error !== 1'b1 || pc !== 10'd0 || sp !== 4'd0) begin
            fails++;
            $display("FAIL underflow: err=%b pc=%0d sp=%0d, want 1 0 0", error, pc, sp);
        end
        do_start();
    endtask

    task automatic test_priority();
        call_en = 1; target = 10'd50;
        tick();
        target = 10'd60;
        tick();
        tests++;
        if (pc !== 10'd60 || sp !== 4'd2) begin
            fails++;
            $display("FAIL nest: pc=%0d sp=%0d, want 60 2", pc, sp);
        end
        call_en = 1; jump_en = 1; ret_en = 1; target = 10'd300;
        tick();
        idle_in();
        tests++;
        if (pc !== 10'd51 || sp !== 4'd1 || error !== 1'b0) begin
            fails++;
            $display("FAIL prio: pc=%0d sp=%0d err=%b, want 51 1 0", pc, sp, error);
        end
        stall = 1; jump_en = 1; target = 10'd400;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (pc !== 10'd51 || sp !== 4'd1 || fetch_valid !== 1'b0) begin
                fails++;
                $display("FAIL stall[%0d]: pc=%0d sp=%0d fv=%b, want 51 1 0", i, pc, sp, fetch_valid);
            end
        end
        idle_in();
        tick();
        tests++;
        if (pc !== 10'd52) begin
            fails++;
            $display("FAIL unstall: pc=%0d, want 52", pc);
        end
    endtask

    task automatic test_halt();
        halt_req = 1; jump_en = 1; target = 10'd9;
        tick();
        idle_in();
        tests++;
        if (pc !== 10'd52 || running !== 1'b0 || error !== 1'b0 || sp !== 4'd1) begin
            fails++;
            $display("FAIL halt: pc=%0d run=%b err=%b sp=%0d, want 52 0 0 1", pc, running, error, sp);
        end
    endtask

    task automatic test_mid_reset();
        do_start();
        tick();
        tick();
        #2 reset = 1;
        #1;
        tests++;
        if (pc !== 10'd0 || running !== 1'b0 || sp !== 4'd0 || fetch_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: pc=%0d run=%b sp=%0d fv=%b, want 0 0 0 0", pc, running, sp, fetch_valid);
        end
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_increment();
        test_wrap();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_priority();
        test_halt();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
